// File: rtl/sudoku_io_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_io_pkg
// Shared constants for the sudoku CPU I/O block: the memory-mapped I/O
// addresses, the push-button bit indices and the display payload type.
// -----------------------------------------------------------------------------
package sudoku_io_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned NUM_BTN = 5;

    // I/O window occupies the top five byte addresses of data memory
    localparam logic [ADDR_W-1:0] IO_BTN    = 8'hFB;
    localparam logic [ADDR_W-1:0] IO_VAL    = 8'hFC;
    localparam logic [ADDR_W-1:0] IO_COMMIT = 8'hFD;
    localparam logic [ADDR_W-1:0] IO_COL    = 8'hFE;
    localparam logic [ADDR_W-1:0] IO_ROW    = 8'hFF;

    // Bit positions of the buttons within the BTN register
    localparam int unsigned BTN_CENTER = 0;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 2;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_UP     = 4;

    // Row/column/value display codes, moved as one unit on commit
    typedef struct packed {
        logic [DATA_W-1:0] row;
        logic [DATA_W-1:0] col;
        logic [DATA_W-1:0] val;
    } disp_t;

endpackage

// File: rtl/sudoku_io_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Single-button debouncer: two-flop synchronizer followed by a stability
// counter. The debounced level flips only after the synchronized level has
// differed from it for DB_CYCLES consecutive cycles.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   i_btn  in   raw asynchronous button level
//   o_db   out  debounced button level (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [DB_W-1:0] r_cnt;

    // Synchronize, then count consecutive cycles of disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_MAX) begin
                    r_db  <= ~r_db;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/sudoku_io.sv
// -----------------------------------------------------------------------------
// sudoku_io
// Memory-mapped I/O responder at data-memory addresses 0xFB..0xFF.
//   0xFB BTN (read-only, debounced buttons), 0xFC VAL, 0xFE COL, 0xFF ROW
//   shadows, 0xFD COMMIT (any write copies the shadows to the display).
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   addr, we, wdata     data-memory bus access for this cycle
//   rdata, io_sel       combinational read data / I/O window select
//   btn                 raw asynchronous buttons
//   disp_row/col/val    committed display codes
//   disp_upd            one-cycle pulse after each commit
// Build option: SUDOKU_IO_BLINK_EN blinks disp_val using a BLINK_W-bit
// free-running divider that restarts on every commit.
// -----------------------------------------------------------------------------
module sudoku_io
    import sudoku_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16,
    parameter int unsigned BLINK_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              io_sel,
    input  logic [NUM_BTN-1:0] btn,
    output logic [DATA_W-1:0] disp_row,
    output logic [DATA_W-1:0] disp_col,
    output logic [DATA_W-1:0] disp_val,
    output logic              disp_upd
);

    logic [NUM_BTN-1:0] w_btn_db;
    logic               w_commit;
    logic [DATA_W-1:0]  w_rdata;
    disp_t              r_shadow;
    disp_t              r_disp;
    logic               r_upd;

    // One debouncer per button
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .i_btn (btn[g]),
            .o_db  (w_btn_db[g])
        );
    end

    assign io_sel   = (addr >= IO_BTN);
    assign w_commit = we && (addr == IO_COMMIT);

    // Shadow capture and atomic commit to the display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_disp   <= '0;
            r_upd    <= 1'b0;
        end else begin
            r_upd <= w_commit;
            if (we) begin
                case (addr)
                    IO_VAL:    r_shadow.val <= wdata;
                    IO_COL:    r_shadow.col <= wdata;
                    IO_ROW:    r_shadow.row <= wdata;
                    IO_COMMIT: r_disp       <= r_shadow;
                    default:   ;
                endcase
            end
        end
    end

    // Zero-cycle read path matching single-cycle data memory
    always_comb begin
        w_rdata = '0;
        case (addr)
            IO_BTN:  w_rdata = DATA_W'(w_btn_db);
            IO_VAL:  w_rdata = r_shadow.val;
            IO_COL:  w_rdata = r_shadow.col;
            IO_ROW:  w_rdata = r_shadow.row;
            default: w_rdata = '0;
        endcase
    end

    assign rdata    = w_rdata;
    assign disp_row = r_disp.row;
    assign disp_col = r_disp.col;
    assign disp_upd = r_upd;

`ifdef SUDOKU_IO_BLINK_EN
    logic [BLINK_W-1:0] r_blink;

    // Restarting on commit shows a fresh value for a full half period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
        end else if (w_commit) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + BLINK_W'(1);
        end
    end

    assign disp_val = r_blink[BLINK_W-1] ? '0 : r_disp.val;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^BLINK_W'(0);
    assign disp_val       = r_disp.val;
`endif

endmodule

// File: tb/tb_sudoku_io.sv
// -----------------------------------------------------------------------------
// tb_sudoku_io
// Directed, table-driven bench for sudoku_io with DB_CYCLES=4, BLINK_W=3.
// -----------------------------------------------------------------------------
module tb_sudoku_io;

    localparam int unsigned TB_DB_CYCLES = 4;
    localparam int unsigned TB_BLINK_W   = 3;
`ifdef SUDOKU_IO_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       io_sel;
    logic [4:0] btn;
    logic [7:0] disp_row;
    logic [7:0] disp_col;
    logic [7:0] disp_val;
    logic       disp_upd;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] m_blink  = 3'd0;

    sudoku_io #(
        .DB_CYCLES (TB_DB_CYCLES),
        .DB_W      (16),
        .BLINK_W   (TB_BLINK_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .io_sel   (io_sel),
        .btn      (btn),
        .disp_row (disp_row),
        .disp_col (disp_col),
        .disp_val (disp_val),
        .disp_upd (disp_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_sel;
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        logic [7:0] exp_val;
        logic       exp_upd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [7:0] a, input logic w, input logic [7:0] d,
                                input logic [7:0] er, input logic es,
                                input logic [7:0] row, input logic [7:0] col,
                                input logic [7:0] val, input logic upd);
        vec_t v;
        v.addr = a; v.we = w; v.wdata = d;
        v.exp_rdata = er; v.exp_sel = es;
        v.exp_row = row; v.exp_col = col; v.exp_val = val; v.exp_upd = upd;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic w, input logic [7:0] d);
        addr  = a;
        we    = w;
        wdata = d;
    endtask

    // Advance one clock; also tracks the expected blink divider
    task automatic tick();
        bit c;
        c = (we && addr == 8'hFD);
        @(posedge clk);
        #1;
        if (rst || c) m_blink = 3'd0;
        else          m_blink = m_blink + 3'd1;
    endtask

    initial begin
        logic [7:0] ev;

        // addr, we, wdata, rdata, sel, row, col, val, upd (after edge)
        vecs[0]  = mk(8'hFB, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[1]  = mk(8'hFF, 1'b1, 8'h11, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[2]  = mk(8'hFE, 1'b1, 8'h22, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[3]  = mk(8'hFC, 1'b1, 8'h33, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[4]  = mk(8'hFF, 1'b0, 8'h00, 8'h11, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[5]  = mk(8'hFE, 1'b0, 8'h00, 8'h22, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[6]  = mk(8'hFC, 1'b0, 8'h00, 8'h33, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[7]  = mk(8'hFD, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
        vecs[8]  = mk(8'hFB, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0);
        vecs[9]  = mk(8'hFB, 1'b1, 8'h55, 8'h00, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0);
        vecs[10] = mk(8'h50, 1'b1, 8'h99, 8'h00, 1'b0, 8'h11, 8'h22, 8'h33, 1'b0);
        vecs[11] = mk(8'h50, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 8'h22, 8'h33, 1'b0);
        vecs[12] = mk(8'hFF, 1'b1, 8'h44, 8'h11, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0);
        vecs[13] = mk(8'hFD, 1'b1, 8'h00, 8'h00, 1'b1, 8'h44, 8'h22, 8'h33, 1'b1);
        vecs[14] = mk(8'hFD, 1'b1, 8'h01, 8'h00, 1'b1, 8'h44, 8'h22, 8'h33, 1'b1);
        vecs[15] = mk(8'hFA, 1'b0, 8'h00, 8'h00, 1'b0, 8'h44, 8'h22, 8'h33, 1'b0);
        vecs[16] = mk(8'hFD, 1'b0, 8'h00, 8'h00, 1'b1, 8'h44, 8'h22, 8'h33, 1'b0);

        // Reset
        rst = 1'b1; btn = 5'b0; apply(8'hFB, 1'b0, 8'h00);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_rdata", rdata, 8'h00);
        check("rst_sel", 8'(io_sel), 8'h01);
        check("rst_row", disp_row, 8'h00);
        check("rst_col", disp_col, 8'h00);
        check("rst_val", disp_val, 8'h00);
        check("rst_upd", 8'(disp_upd), 8'h00);

        // Table of single-cycle bus accesses
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].addr, vecs[i].we, vecs[i].wdata);
            #1;
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_sel", i), 8'(io_sel), 8'(vecs[i].exp_sel));
            tick();
            ev = (BLINK_ON && m_blink[2]) ? 8'h00 : vecs[i].exp_val;
            check($sformatf("v%0d_row", i), disp_row, vecs[i].exp_row);
            check($sformatf("v%0d_col", i), disp_col, vecs[i].exp_col);
            check($sformatf("v%0d_val", i), disp_val, ev);
            check($sformatf("v%0d_upd", i), 8'(disp_upd), 8'(vecs[i].exp_upd));
        end

        // Press left: visible exactly 2 + DB_CYCLES edges later
        apply(8'hFB, 1'b0, 8'h00);
        btn = 5'b00010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("press_k%0d", k), rdata, (k >= 6) ? 8'h02 : 8'h00);
        end
        btn = 5'b00000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("release_k%0d", k), rdata, (k >= 6) ? 8'h00 : 8'h02);
        end

        // Glitch shorter than DB_CYCLES is rejected
        btn = 5'b00100;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("glitch_hi_k%0d", k), rdata, 8'h00);
        end
        btn = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("glitch_lo_k%0d", k), rdata, 8'h00);
        end

        // Reset mid-debounce and after a commit
        btn = 5'b00001;
        for (int k = 1; k <= 4; k++) tick();
        check("middb_rdata", rdata, 8'h00);
        check("precommit_row", disp_row, 8'h44);
        rst = 1'b1;
        apply(8'hFF, 1'b0, 8'h00);
        #1;
        check("arst_row_shadow", rdata, 8'h00);
        check("arst_row", disp_row, 8'h00);
        check("arst_col", disp_col, 8'h00);
        check("arst_val", disp_val, 8'h00);
        check("arst_upd", 8'(disp_upd), 8'h00);
        tick();
        rst = 1'b0;
        apply(8'hFB, 1'b0, 8'h00);
        #1;
        check("arst_btn", rdata, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("repress_k%0d", k), rdata, (k >= 6) ? 8'h01 : 8'h00);
        end
        btn = 5'b00000;

`ifdef SUDOKU_IO_BLINK_EN
        // Blink: 4 cycles shown, 4 cycles blank, restart on commit
        apply(8'hFC, 1'b1, 8'h33); tick();
        apply(8'hFD, 1'b1, 8'h00); tick();
        apply(8'hFB, 1'b0, 8'h00);
        check("blink_k0", disp_val, 8'h33);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check($sformatf("blink_k%0d", k), disp_val, ((k % 8) >= 4) ? 8'h00 : 8'h33);
        end
        tick(); tick();
        check("blink_blank", disp_val, 8'h00);
        apply(8'hFD, 1'b1, 8'h00); tick();
        apply(8'hFB, 1'b0, 8'h00);
        check("blink_recommit", disp_val, 8'h33);
        check("blink_row", disp_row, 8'h00);
        tick();
        check("blink_recommit_k1", disp_val, 8'h33);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
